// File: rtl/counter_pkg.sv
// Shared types and command decode for the modulo up/down counter.
package counter_pkg;

  // Per-edge command, in priority order of the decode below.
  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_LOAD,
    CMD_CLIP,
    CMD_UP,
    CMD_DOWN
  } count_cmd_e;

  // Load beats clip-to-limit, which beats counting; both count inputs high is a hold.
  function automatic count_cmd_e decode_cmd(input logic load,
                                            input logic over_limit,
                                            input logic up,
                                            input logic down);
    count_cmd_e cmd;
    if (load) begin
      cmd = CMD_LOAD;
    end else if (over_limit) begin
      cmd = CMD_CLIP;
    end else if (up && !down) begin
      cmd = CMD_UP;
    end else if (down && !up) begin
      cmd = CMD_DOWN;
    end else begin
      cmd = CMD_HOLD;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/mod_step_calc.sv
// Combinational step arithmetic: next value for one up/down step within 0..lim,
// wrapping modulo lim+1 or saturating at the bounds. Works at WIDTH+1 bits so
// q+s and q+lim+1 never overflow. Caller guarantees q <= lim and s <= lim.
module mod_step_calc #(
  parameter int unsigned WIDTH = 7
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] lim,
  input  logic             up,
  input  logic             sat_mode,
  output logic [WIDTH:0]   nxt,
  output logic             wrap,
  output logic             clip
);

  localparam logic [WIDTH:0] One = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] q_x;
  logic [WIDTH:0] s_x;
  logic [WIDTH:0] l_x;
  logic [WIDTH:0] sum;

  assign q_x = {1'b0, q};
  assign s_x = {1'b0, s};
  assign l_x = {1'b0, lim};
  assign sum = q_x + s_x;

  // Select wrapped, saturated or plain result for the requested direction.
  always_comb begin
    nxt  = q_x;
    wrap = 1'b0;
    clip = 1'b0;
    if (up) begin
      if (sum > l_x) begin
        if (sat_mode) begin
          nxt  = l_x;
          clip = 1'b1;
        end else begin
          nxt  = sum - l_x - One;
          wrap = 1'b1;
        end
      end else begin
        nxt = sum;
      end
    end else begin
      if (q_x >= s_x) begin
        nxt = q_x - s_x;
      end else if (sat_mode) begin
        nxt  = '0;
        clip = 1'b1;
      end else begin
        // q < s here, so the result lands back inside 0..lim.
        nxt  = q_x + l_x + One - s_x;
        wrap = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Loadable up/down counter with runtime modulo limit, programmable step and
// wrap/saturate mode. Registered wrap/sat event pulses, combinational bounds.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  d,
  input  logic              load,
  input  logic              countup,
  input  logic              countdown,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  input  logic              sat_mode,
  output logic [WIDTH-1:0]  q,
  output logic              wrap,
  output logic              sat,
  output logic              at_max,
  output logic              at_min
);

  // Common width for comparing step against limit, whichever is wider.
  localparam int unsigned CmpW = (WIDTH > STEP_W) ? WIDTH : STEP_W;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;

  logic [CmpW-1:0]  step_x;
  logic [CmpW-1:0]  lim_x;
  logic [WIDTH-1:0] eff_step;
  count_cmd_e       cmd;

  logic [WIDTH:0]   calc_nxt;
  logic             calc_wrap;
  logic             calc_clip;
  logic             unused_calc_msb;

  assign step_x   = CmpW'(step);
  assign lim_x    = CmpW'(limit);
  // A step larger than the range is clamped to the limit (limit 0 gives step 0).
  assign eff_step = (step_x > lim_x) ? limit : step_x[WIDTH-1:0];

  assign cmd = decode_cmd(load, (cnt_q > limit), countup, countdown);

  mod_step_calc #(
    .WIDTH (WIDTH)
  ) u_step_calc (
    .q        (cnt_q),
    .s        (eff_step),
    .lim      (limit),
    .up       (cmd == CMD_UP),
    .sat_mode (sat_mode),
    .nxt      (calc_nxt),
    .wrap     (calc_wrap),
    .clip     (calc_clip)
  );

  // Result is always <= limit, so the extra arithmetic bit is zero here.
  assign unused_calc_msb = calc_nxt[WIDTH];

  // Next count and event flags from the decoded command.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    unique case (cmd)
      CMD_LOAD: begin
        if (d > limit) begin
          cnt_d = limit;
          sat_d = 1'b1;
        end else begin
          cnt_d = d;
        end
      end
      CMD_CLIP: begin
        cnt_d = limit;
        sat_d = 1'b1;
      end
      CMD_UP, CMD_DOWN: begin
        cnt_d  = calc_nxt[WIDTH-1:0];
        wrap_d = calc_wrap;
        sat_d  = calc_clip;
      end
      default: ;
    endcase
  end

  // Count and flag registers; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign q      = cnt_q;
  assign wrap   = wrap_q;
  assign sat    = sat_q;
  assign at_max = (cnt_q == limit);
  assign at_min = (cnt_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: integer reference model checked every
// cycle, plus literal expectations from hand-worked scenarios.
module tb_mod_updown_counter;

  localparam int unsigned WIDTH  = 7;
  localparam int unsigned STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [WIDTH-1:0]  d = '0;
  logic              load = 1'b0;
  logic              countup = 1'b0;
  logic              countdown = 1'b0;
  logic [WIDTH-1:0]  limit = '0;
  logic [STEP_W-1:0] step = '0;
  logic              sat_mode = 1'b0;
  logic [WIDTH-1:0]  q;
  logic              wrap;
  logic              sat;
  logic              at_max;
  logic              at_min;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference state.
  int mq    = 0;
  bit mwrap = 1'b0;
  bit msat  = 1'b0;

  mod_updown_counter #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .load      (load),
    .countup   (countup),
    .countdown (countdown),
    .limit     (limit),
    .step      (step),
    .sat_mode  (sat_mode),
    .q         (q),
    .wrap      (wrap),
    .sat       (sat),
    .at_max    (at_max),
    .at_min    (at_min)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Reference model: range 0..L, modular/saturating arithmetic on plain ints.
  always @(posedge clk or negedge rst) begin
    int lim_i, s, nq;
    bit w, c;
    if (!rst) begin
      mq    = 0;
      mwrap = 1'b0;
      msat  = 1'b0;
    end else begin
      lim_i = int'(limit);
      s     = (int'(step) > lim_i) ? lim_i : int'(step);
      nq    = mq;
      w     = 1'b0;
      c     = 1'b0;
      if (load) begin
        if (int'(d) > lim_i) begin
          nq = lim_i;
          c  = 1'b1;
        end else begin
          nq = int'(d);
        end
      end else if (mq > lim_i) begin
        nq = lim_i;
        c  = 1'b1;
      end else if (countup != countdown) begin
        if (countup) begin
          if (mq + s <= lim_i) nq = mq + s;
          else if (sat_mode) begin
            nq = lim_i;
            c  = 1'b1;
          end else begin
            nq = (mq + s) % (lim_i + 1);
            w  = 1'b1;
          end
        end else begin
          if (mq >= s) nq = mq - s;
          else if (sat_mode) begin
            nq = 0;
            c  = 1'b1;
          end else begin
            nq = (mq - s + lim_i + 1) % (lim_i + 1);
            w  = 1'b1;
          end
        end
      end
      mq    = nq;
      mwrap = w;
      msat  = c;
    end
  end

  // Compare DUT against the model mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model q", int'(q), mq);
      check("model wrap", int'(wrap), int'(mwrap));
      check("model sat", int'(sat), int'(msat));
      check("model at_max", int'(at_max), int'(mq == int'(limit)));
      check("model at_min", int'(at_min), int'(mq == 0));
    end
  end

  // One clock with the given command; returns 1 time unit after the edge.
  task automatic cyc(input bit ld, input bit up, input bit dn, input int dv);
    load      = ld;
    countup   = up;
    countdown = dn;
    d         = WIDTH'(dv);
    @(posedge clk);
    #1;
    load      = 1'b0;
    countup   = 1'b0;
    countdown = 1'b0;
  endtask

  initial begin
    // Reset with no clock edge yet.
    #2;
    check("por q", int'(q), 0);
    check("por at_min", int'(at_min), 1);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    chk_en = 1'b1;

    // 1: reset mid-count
    limit = 7'd100; step = 4'd1; sat_mode = 1'b0;
    cyc(1, 0, 0, 37);
    check("t1 load37", int'(q), 37);
    countup = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("t1 async q", int'(q), 0);
    check("t1 async wrap", int'(wrap), 0);
    check("t1 async sat", int'(sat), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t1 held q", int'(q), 0);
    countup = 1'b0;
    rst     = 1'b1;
    cyc(0, 0, 0, 0);
    check("t1 idle q", int'(q), 0);
    check("t1 at_min", int'(at_min), 1);

    // 2: load clamp
    limit = 7'd9;
    cyc(1, 0, 0, 5);
    check("t2 q5", int'(q), 5);
    check("t2 sat0", int'(sat), 0);
    cyc(1, 0, 0, 12);
    check("t2 q9", int'(q), 9);
    check("t2 sat1", int'(sat), 1);
    check("t2 at_max", int'(at_max), 1);
    cyc(0, 0, 0, 0);
    check("t2 sat pulse end", int'(sat), 0);

    // 3: wrap up and down
    step = 4'd3;
    cyc(1, 0, 0, 8);
    cyc(0, 1, 0, 0);
    check("t3 up q", int'(q), 1);
    check("t3 up wrap", int'(wrap), 1);
    cyc(0, 0, 1, 0);
    check("t3 dn q", int'(q), 8);
    check("t3 dn wrap", int'(wrap), 1);
    step = 4'd15;
    cyc(1, 0, 0, 1);
    check("t3 load1 wrap0", int'(wrap), 0);
    cyc(0, 1, 0, 0);
    check("t3 clamp q", int'(q), 0);
    check("t3 clamp wrap", int'(wrap), 1);

    // 4: saturate
    limit = 7'd100; sat_mode = 1'b1; step = 4'd5;
    cyc(1, 0, 0, 2);
    cyc(0, 0, 1, 0);
    check("t4 dn q", int'(q), 0);
    check("t4 dn sat", int'(sat), 1);
    cyc(0, 0, 1, 0);
    check("t4 dn2 q", int'(q), 0);
    check("t4 dn2 sat", int'(sat), 1);
    cyc(1, 0, 0, 98);
    cyc(0, 1, 0, 0);
    check("t4 up q", int'(q), 100);
    check("t4 up sat", int'(sat), 1);
    check("t4 up wrap", int'(wrap), 0);

    // 5: priority
    cyc(1, 1, 1, 4);
    check("t5 load wins", int'(q), 4);
    cyc(0, 1, 1, 0);
    check("t5 both hold", int'(q), 4);
    check("t5 both flags", int'(wrap) + int'(sat), 0);
    step = 4'd0;
    cyc(0, 1, 0, 0);
    check("t5 step0 hold", int'(q), 4);
    check("t5 step0 flags", int'(wrap) + int'(sat), 0);

    // 6: limit shrink and full range
    sat_mode = 1'b0; step = 4'd1;
    cyc(1, 0, 0, 50);
    cyc(0, 0, 0, 0);
    limit = 7'd20;
    cyc(0, 1, 0, 0);
    check("t6 shrink q", int'(q), 20);
    check("t6 shrink sat", int'(sat), 1);
    cyc(0, 0, 0, 0);
    check("t6 no pulse", int'(sat), 0);
    limit = 7'd127;
    cyc(1, 0, 0, 127);
    check("t6 at_max", int'(at_max), 1);
    cyc(0, 1, 0, 0);
    check("t6 full wrap q", int'(q), 0);
    check("t6 full wrap", int'(wrap), 1);

    // Mixed command sweep, checked by the model only.
    limit = 7'd13;
    for (int i = 0; i < 48; i++) begin
      step     = STEP_W'(i % 7);
      sat_mode = ((i / 12) % 2) == 1;
      if (i == 24) limit = 7'd5;
      if (i == 36) limit = 7'd0;
      cyc((i % 11) == 0, (i % 3) == 0, (i % 4) == 1, (i * 7) % 128);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
